// File: rtl/sim_axi_mem_pkg.sv
// Shared types and helpers for the sim_axi_mem AXI4 slave memory model.
package sim_axi_mem_pkg;

  localparam logic [1:0] BurstFixed = 2'd0;
  localparam logic [1:0] BurstIncr  = 2'd1;
  localparam logic [1:0] BurstWrap  = 2'd2;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;
  localparam logic [1:0] RespDecerr = 2'b11;

  // Descriptor fields are sized for the widest supported configuration (ID_BITS <= 16).
  localparam int unsigned DescAddrBits = 64;
  localparam int unsigned DescIdBits   = 16;

  typedef enum logic [1:0] {RIdle, RWait, RBurst} r_state_e;
  typedef enum logic [1:0] {WIdle, WData, WWait, WResp} w_state_e;

  typedef struct packed {
    logic [DescAddrBits-1:0] addr;
    logic [7:0]              len;
    logic [2:0]              size;
    logic [1:0]              burst;
    logic [DescIdBits-1:0]   id;
    logic [1:0]              err;
  } beat_desc_t;

  function automatic logic is_wrap_len(input logic [7:0] len);
    return len inside {8'd1, 8'd3, 8'd7, 8'd15};
  endfunction

  // Start address of the highest-addressed beat of a burst; used for the range check.
  function automatic logic [63:0] last_beat_addr(input beat_desc_t d);
    logic [63:0] beat_bytes;
    logic [63:0] span;
    logic [63:0] aligned;
    beat_bytes = 64'd1 << d.size;
    span       = (64'(d.len) + 64'd1) << d.size;
    aligned    = d.addr & ~(beat_bytes - 64'd1);
    if (d.burst == BurstFixed) return d.addr;
    if (d.burst == BurstWrap && is_wrap_len(d.len)) return (d.addr & ~(span - 64'd1)) + span - beat_bytes;
    return aligned + (64'(d.len) << d.size);
  endfunction

endpackage

// File: rtl/sim_axi_mem_addr_gen.sv
// Beat address generator: burst descriptor plus beat number in, byte address and word index out.
module sim_axi_mem_addr_gen
  import sim_axi_mem_pkg::*;
#(
  parameter int unsigned     ADDR_BITS = 32,
  parameter int unsigned     DATA_BITS = 64,
  parameter int unsigned     IDX_BITS  = 12,
  parameter longint unsigned MEM_BASE  = 0
) (
  input  beat_desc_t           desc_i,
  input  logic [7:0]           beat_i,
  output logic [ADDR_BITS-1:0] beat_addr_o,
  output logic [IDX_BITS-1:0]  word_idx_o
);

  localparam int unsigned ByteShift = $clog2(DATA_BITS / 8);

  logic [63:0] beat_bytes;
  logic [63:0] aligned;
  logic [63:0] incr_addr;
  logic [63:0] span;
  logic [63:0] wrap_base;
  logic [63:0] addr_full;
  logic [63:0] word_full;

  // Beat address per burst type; WRAP with an illegal len falls back to INCR.
  always_comb begin
    beat_bytes = 64'd1 << desc_i.size;
    aligned    = desc_i.addr & ~(beat_bytes - 64'd1);
    incr_addr  = aligned + (64'(beat_i) << desc_i.size);
    span       = (64'(desc_i.len) + 64'd1) << desc_i.size;
    wrap_base  = desc_i.addr & ~(span - 64'd1);
    addr_full  = incr_addr;
    case (desc_i.burst)
      BurstFixed: addr_full = desc_i.addr;
      BurstWrap: begin
        if (is_wrap_len(desc_i.len)) begin
          addr_full = wrap_base + ((incr_addr - wrap_base) & (span - 64'd1));
        end
      end
      default: ;
    endcase
    word_full = (addr_full - 64'(MEM_BASE)) >> ByteShift;
  end

  assign beat_addr_o = addr_full[ADDR_BITS-1:0];
  assign word_idx_o  = word_full[IDX_BITS-1:0];

  logic unused_bits;
  assign unused_bits = ^{desc_i.id, desc_i.err, addr_full[63:ADDR_BITS], word_full[63:IDX_BITS]};

endmodule

// File: rtl/sim_axi_mem.sv
// AXI4 slave memory model: independent read and write engines over one word array.
module sim_axi_mem
  import sim_axi_mem_pkg::*;
#(
  parameter int unsigned     ADDR_BITS     = 32,
  parameter int unsigned     DATA_BITS     = 64,
  parameter int unsigned     ID_BITS       = 5,
  parameter int unsigned     MEM_WORDS     = 4096,
  parameter longint unsigned MEM_BASE      = 0,
  parameter int unsigned     READ_LATENCY  = 4,
  parameter int unsigned     WRITE_LATENCY = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  output logic                   axi_aw_ready,
  input  logic                   axi_aw_valid,
  input  logic [ADDR_BITS-1:0]   axi_aw_bits_addr,
  input  logic [7:0]             axi_aw_bits_len,
  input  logic [2:0]             axi_aw_bits_size,
  input  logic [1:0]             axi_aw_bits_burst,
  input  logic [ID_BITS-1:0]     axi_aw_bits_id,
  output logic                   axi_w_ready,
  input  logic                   axi_w_valid,
  input  logic [DATA_BITS-1:0]   axi_w_bits_data,
  input  logic [DATA_BITS/8-1:0] axi_w_bits_strb,
  input  logic                   axi_w_bits_last,
  input  logic                   axi_b_ready,
  output logic                   axi_b_valid,
  output logic [1:0]             axi_b_bits_resp,
  output logic [ID_BITS-1:0]     axi_b_bits_id,
  output logic                   axi_ar_ready,
  input  logic                   axi_ar_valid,
  input  logic [ADDR_BITS-1:0]   axi_ar_bits_addr,
  input  logic [7:0]             axi_ar_bits_len,
  input  logic [2:0]             axi_ar_bits_size,
  input  logic [1:0]             axi_ar_bits_burst,
  input  logic [ID_BITS-1:0]     axi_ar_bits_id,
  input  logic                   axi_r_ready,
  output logic                   axi_r_valid,
  output logic [DATA_BITS-1:0]   axi_r_bits_data,
  output logic [1:0]             axi_r_bits_resp,
  output logic                   axi_r_bits_last,
  output logic [ID_BITS-1:0]     axi_r_bits_id
);

  localparam int unsigned     StrbBits = DATA_BITS / 8;
  localparam int unsigned     IdxBits  = $clog2(MEM_WORDS);
  localparam logic [2:0]      MaxSize  = 3'($clog2(StrbBits));
  localparam longint unsigned MemBytes = 64'(MEM_WORDS) * 64'(StrbBits);

  // Whole-burst response, decided once at address capture.
  function automatic logic [1:0] classify(input beat_desc_t d);
    logic [63:0] hi;
    hi = last_beat_addr(d);
    if (d.addr < 64'(MEM_BASE) || (hi - 64'(MEM_BASE)) >= MemBytes) return RespDecerr;
    if (d.size > MaxSize) return RespSlverr;
    return RespOkay;
  endfunction

  logic [DATA_BITS-1:0] mem_q [MEM_WORDS];

  // Holds the ready outputs low until the first clock edge after reset.
  logic out_en_q;

  r_state_e             r_state_q, r_state_d;
  beat_desc_t           rd_desc_q, rd_desc_d, ar_desc;
  logic [15:0]          r_cnt_q, r_cnt_d;
  logic [7:0]           r_beat_q, r_beat_d, r_fetch_beat;
  logic [DATA_BITS-1:0] r_data_q, r_data_d;
  logic [1:0]           r_resp_q, r_resp_d;
  logic                 r_last_q, r_last_d, r_load;
  logic [IdxBits-1:0]   r_word_idx;
  logic [ADDR_BITS-1:0] r_beat_addr;

  w_state_e             w_state_q, w_state_d;
  beat_desc_t           wr_desc_q, wr_desc_d, aw_desc;
  logic [15:0]          w_cnt_q, w_cnt_d;
  logic [7:0]           w_beat_q, w_beat_d;
  logic [1:0]           b_resp_q, b_resp_d;
  logic                 mem_we;
  logic [IdxBits-1:0]   w_word_idx;
  logic [ADDR_BITS-1:0] w_beat_addr;

  sim_axi_mem_addr_gen #(
    .ADDR_BITS(ADDR_BITS),
    .DATA_BITS(DATA_BITS),
    .IDX_BITS (IdxBits),
    .MEM_BASE (MEM_BASE)
  ) u_rd_addr_gen (
    .desc_i     (rd_desc_q),
    .beat_i     (r_fetch_beat),
    .beat_addr_o(r_beat_addr),
    .word_idx_o (r_word_idx)
  );

  sim_axi_mem_addr_gen #(
    .ADDR_BITS(ADDR_BITS),
    .DATA_BITS(DATA_BITS),
    .IDX_BITS (IdxBits),
    .MEM_BASE (MEM_BASE)
  ) u_wr_addr_gen (
    .desc_i     (wr_desc_q),
    .beat_i     (w_beat_q),
    .beat_addr_o(w_beat_addr),
    .word_idx_o (w_word_idx)
  );

  // Capture descriptors straight off the address channels.
  always_comb begin
    ar_desc       = '0;
    ar_desc.addr  = 64'(axi_ar_bits_addr);
    ar_desc.len   = axi_ar_bits_len;
    ar_desc.size  = axi_ar_bits_size;
    ar_desc.burst = axi_ar_bits_burst;
    ar_desc.id    = 16'(axi_ar_bits_id);
    ar_desc.err   = classify(ar_desc);
    aw_desc       = '0;
    aw_desc.addr  = 64'(axi_aw_bits_addr);
    aw_desc.len   = axi_aw_bits_len;
    aw_desc.size  = axi_aw_bits_size;
    aw_desc.burst = axi_aw_bits_burst;
    aw_desc.id    = 16'(axi_aw_bits_id);
    aw_desc.err   = classify(aw_desc);
  end

  // Read engine next state; r_data is loaded one beat ahead so it is stable while r_valid is high.
  always_comb begin
    r_state_d    = r_state_q;
    rd_desc_d    = rd_desc_q;
    r_cnt_d      = r_cnt_q;
    r_beat_d     = r_beat_q;
    r_data_d     = r_data_q;
    r_resp_d     = r_resp_q;
    r_last_d     = r_last_q;
    r_load       = 1'b0;
    r_fetch_beat = (r_state_q == RBurst) ? r_beat_q + 8'd1 : 8'd0;
    case (r_state_q)
      RIdle: begin
        if (axi_ar_ready && axi_ar_valid) begin
          rd_desc_d = ar_desc;
          r_cnt_d   = 16'(READ_LATENCY - 1);
          r_beat_d  = 8'd0;
          r_state_d = RWait;
        end
      end
      RWait: begin
        if (r_cnt_q == '0) begin
          r_load    = 1'b1;
          r_state_d = RBurst;
        end else begin
          r_cnt_d = r_cnt_q - 16'd1;
        end
      end
      RBurst: begin
        if (axi_r_ready) begin
          if (r_last_q) begin
            r_state_d = RIdle;
          end else begin
            r_beat_d = r_beat_q + 8'd1;
            r_load   = 1'b1;
          end
        end
      end
      default: r_state_d = RIdle;
    endcase
    if (r_load) begin
      r_data_d = (rd_desc_q.err == RespOkay) ? mem_q[r_word_idx] : '0;
      r_resp_d = rd_desc_q.err;
      r_last_d = (r_fetch_beat == rd_desc_q.len);
    end
  end

  // Read engine state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_en_q  <= 1'b0;
      r_state_q <= RIdle;
      rd_desc_q <= '0;
      r_cnt_q   <= '0;
      r_beat_q  <= '0;
      r_data_q  <= '0;
      r_resp_q  <= RespOkay;
      r_last_q  <= 1'b0;
    end else begin
      out_en_q  <= 1'b1;
      r_state_q <= r_state_d;
      rd_desc_q <= rd_desc_d;
      r_cnt_q   <= r_cnt_d;
      r_beat_q  <= r_beat_d;
      r_data_q  <= r_data_d;
      r_resp_q  <= r_resp_d;
      r_last_q  <= r_last_d;
    end
  end

  // Write engine next state; beats past len are accepted but never committed.
  always_comb begin
    w_state_d = w_state_q;
    wr_desc_d = wr_desc_q;
    w_cnt_d   = w_cnt_q;
    w_beat_d  = w_beat_q;
    b_resp_d  = b_resp_q;
    mem_we    = 1'b0;
    case (w_state_q)
      WIdle: begin
        if (axi_aw_ready && axi_aw_valid) begin
          wr_desc_d = aw_desc;
          w_beat_d  = 8'd0;
          w_state_d = WData;
        end
      end
      WData: begin
        if (axi_w_valid) begin
          mem_we = (wr_desc_q.err == RespOkay) && (w_beat_q <= wr_desc_q.len);
          if (axi_w_bits_last) begin
            w_cnt_d   = 16'(WRITE_LATENCY - 1);
            w_state_d = WWait;
            if (wr_desc_q.err != RespOkay) b_resp_d = wr_desc_q.err;
            else b_resp_d = (w_beat_q == wr_desc_q.len) ? RespOkay : RespSlverr;
          end else if (w_beat_q != 8'hff) begin
            w_beat_d = w_beat_q + 8'd1;
          end
        end
      end
      WWait: begin
        if (w_cnt_q == '0) w_state_d = WResp;
        else w_cnt_d = w_cnt_q - 16'd1;
      end
      WResp: begin
        if (axi_b_ready) w_state_d = WIdle;
      end
      default: w_state_d = WIdle;
    endcase
  end

  // Write engine state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      w_state_q <= WIdle;
      wr_desc_q <= '0;
      w_cnt_q   <= '0;
      w_beat_q  <= '0;
      b_resp_q  <= RespOkay;
    end else begin
      w_state_q <= w_state_d;
      wr_desc_q <= wr_desc_d;
      w_cnt_q   <= w_cnt_d;
      w_beat_q  <= w_beat_d;
      b_resp_q  <= b_resp_d;
    end
  end

  // Byte-strobed array write; contents survive reset.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      for (int i = 0; i < int'(StrbBits); i++) begin
        if (axi_w_bits_strb[i]) mem_q[w_word_idx][i*8 +: 8] <= axi_w_bits_data[i*8 +: 8];
      end
    end
  end

  assign axi_ar_ready    = out_en_q && (r_state_q == RIdle);
  assign axi_r_valid     = (r_state_q == RBurst);
  assign axi_r_bits_data = r_data_q;
  assign axi_r_bits_resp = r_resp_q;
  assign axi_r_bits_last = r_last_q;
  assign axi_r_bits_id   = rd_desc_q.id[ID_BITS-1:0];

  assign axi_aw_ready    = out_en_q && (w_state_q == WIdle);
  assign axi_w_ready     = (w_state_q == WData);
  assign axi_b_valid     = (w_state_q == WResp);
  assign axi_b_bits_resp = b_resp_q;
  assign axi_b_bits_id   = wr_desc_q.id[ID_BITS-1:0];

  logic unused_bits;
  assign unused_bits = ^{rd_desc_q.id, wr_desc_q.id, r_beat_addr, w_beat_addr};

endmodule

// File: tb/tb_sim_axi_mem.sv
// Directed bench for sim_axi_mem: bursts, narrow writes, errors, backpressure and reset.
module tb_sim_axi_mem;

  localparam logic [31:0] Base = 32'h0001_0000;
  localparam logic [1:0]  BFix = 2'd0;
  localparam logic [1:0]  BInc = 2'd1;
  localparam logic [1:0]  BWrp = 2'd2;

  logic        clock = 1'b0;
  logic        reset;
  logic        aw_ready, aw_valid;
  logic [31:0] aw_addr;
  logic [7:0]  aw_len;
  logic [2:0]  aw_size;
  logic [1:0]  aw_burst;
  logic [4:0]  aw_id;
  logic        w_ready, w_valid, w_last;
  logic [63:0] w_data;
  logic [7:0]  w_strb;
  logic        b_ready, b_valid;
  logic [1:0]  b_resp;
  logic [4:0]  b_id;
  logic        ar_ready, ar_valid;
  logic [31:0] ar_addr;
  logic [7:0]  ar_len;
  logic [2:0]  ar_size;
  logic [1:0]  ar_burst;
  logic [4:0]  ar_id;
  logic        r_ready, r_valid, r_last;
  logic [63:0] r_data;
  logic [1:0]  r_resp;
  logic [4:0]  r_id;

  sim_axi_mem #(
    .ADDR_BITS    (32),
    .DATA_BITS    (64),
    .ID_BITS      (5),
    .MEM_WORDS    (256),
    .MEM_BASE     (64'h1_0000),
    .READ_LATENCY (4),
    .WRITE_LATENCY(2)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .axi_aw_ready     (aw_ready),
    .axi_aw_valid     (aw_valid),
    .axi_aw_bits_addr (aw_addr),
    .axi_aw_bits_len  (aw_len),
    .axi_aw_bits_size (aw_size),
    .axi_aw_bits_burst(aw_burst),
    .axi_aw_bits_id   (aw_id),
    .axi_w_ready      (w_ready),
    .axi_w_valid      (w_valid),
    .axi_w_bits_data  (w_data),
    .axi_w_bits_strb  (w_strb),
    .axi_w_bits_last  (w_last),
    .axi_b_ready      (b_ready),
    .axi_b_valid      (b_valid),
    .axi_b_bits_resp  (b_resp),
    .axi_b_bits_id    (b_id),
    .axi_ar_ready     (ar_ready),
    .axi_ar_valid     (ar_valid),
    .axi_ar_bits_addr (ar_addr),
    .axi_ar_bits_len  (ar_len),
    .axi_ar_bits_size (ar_size),
    .axi_ar_bits_burst(ar_burst),
    .axi_ar_bits_id   (ar_id),
    .axi_r_ready      (r_ready),
    .axi_r_valid      (r_valid),
    .axi_r_bits_data  (r_data),
    .axi_r_bits_resp  (r_resp),
    .axi_r_bits_last  (r_last),
    .axi_r_bits_id    (r_id)
  );

  always #5 clock = ~clock;

  int          n_checks = 0;
  int          n_pass = 0;
  logic [63:0] wdata [16];
  logic [7:0]  wstrb [16];
  logic [63:0] rdata [16];
  logic [1:0]  rresp [16];
  logic        rlast [16];
  logic [4:0]  rid;
  logic [1:0]  bresp;
  logic [4:0]  bid;
  int          rlat, wlat;
  logic        ar_busy_ok, b2b_ok, stall_ok, end_ok;

  logic [63:0] dpat [4];
  logic [63:0] wpat [4];

  task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [4:0] id, input int last_at);
    int t;
    aw_addr = addr; aw_len = len; aw_size = size; aw_burst = burst; aw_id = id; aw_valid = 1'b1;
    t = 0;
    @(negedge clock);
    while (!aw_ready && t < 50) begin @(negedge clock); t++; end
    if (!aw_ready) begin
      n_checks++;
      $display("FAIL aw_timeout: aw_ready=%b required 1", aw_ready);
      aw_valid = 1'b0;
      return;
    end
    @(posedge clock); #1 aw_valid = 1'b0;
    for (int i = 0; i <= last_at; i++) begin
      w_valid = 1'b1; w_data = wdata[i]; w_strb = wstrb[i]; w_last = (i == last_at);
      t = 0;
      @(negedge clock);
      while (!w_ready && t < 50) begin @(negedge clock); t++; end
      if (!w_ready) begin
        n_checks++;
        $display("FAIL w_timeout: w_ready=%b required 1 at beat %0d", w_ready, i);
        w_valid = 1'b0; w_last = 1'b0;
        return;
      end
      @(posedge clock); #1;
    end
    w_valid = 1'b0; w_last = 1'b0;
    wlat = 0;
    do begin
      @(posedge clock); wlat++;
      @(negedge clock);
    end while (!b_valid && wlat < 50);
    if (!b_valid) begin
      n_checks++;
      $display("FAIL b_timeout: b_valid=%b required 1", b_valid);
      return;
    end
    bresp = b_resp; bid = b_id;
    @(posedge clock); #1;
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input logic [4:0] id, input int stall_beat);
    int t;
    ar_addr = addr; ar_len = len; ar_size = size; ar_burst = burst; ar_id = id; ar_valid = 1'b1;
    r_ready = 1'b1;
    ar_busy_ok = 1'b1; b2b_ok = 1'b1; stall_ok = 1'b1; end_ok = 1'b1;
    t = 0;
    @(negedge clock);
    while (!ar_ready && t < 50) begin @(negedge clock); t++; end
    if (!ar_ready) begin
      n_checks++;
      $display("FAIL ar_timeout: ar_ready=%b required 1", ar_ready);
      ar_valid = 1'b0;
      return;
    end
    @(posedge clock); #1 ar_valid = 1'b0;
    rlat = 0;
    do begin
      @(posedge clock); rlat++;
      @(negedge clock);
    end while (!r_valid && rlat < 50);
    if (!r_valid) begin
      n_checks++;
      $display("FAIL r_timeout: r_valid=%b required 1", r_valid);
      return;
    end
    for (int b = 0; b <= int'(len); b++) begin
      if (b > 0) begin
        @(negedge clock);
        if (!r_valid) begin
          b2b_ok = 1'b0;
          t = 0;
          while (!r_valid && t < 50) begin @(negedge clock); t++; end
        end
      end
      rdata[b] = r_data; rresp[b] = r_resp; rlast[b] = r_last; rid = r_id;
      if (ar_ready) ar_busy_ok = 1'b0;
      if (b == stall_beat) begin
        r_ready = 1'b0;
        repeat (5) begin
          @(posedge clock);
          @(negedge clock);
          if (!r_valid || r_data !== rdata[b] || r_last !== rlast[b] || r_resp !== rresp[b])
            stall_ok = 1'b0;
          if (ar_ready) ar_busy_ok = 1'b0;
        end
        r_ready = 1'b1;
      end
      @(posedge clock); #1;
    end
    if (r_valid) end_ok = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if ({ar_ready, aw_ready, w_ready, r_valid, b_valid} !== 5'b0)
      $display("FAIL reset_handshakes: ar/aw/w/r/b=%b required 00000",
               {ar_ready, aw_ready, w_ready, r_valid, b_valid});
    else n_pass++;
    n_checks++;
    if ({r_data, r_resp, r_last, r_id, b_resp, b_id} !== '0)
      $display("FAIL reset_payload: r_data=%h r_resp=%b r_last=%b r_id=%h b_resp=%b b_id=%h required 0",
               r_data, r_resp, r_last, r_id, b_resp, b_id);
    else n_pass++;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    n_checks++;
    if (ar_ready !== 1'b0) $display("FAIL ready_before_edge: ar_ready=%b required 0", ar_ready);
    else n_pass++;
    @(posedge clock); #1;
    n_checks++;
    if ({ar_ready, aw_ready} !== 2'b11)
      $display("FAIL ready_first_edge: ar/aw=%b required 11", {ar_ready, aw_ready});
    else n_pass++;
  endtask

  task automatic test_incr_read();
    for (int i = 0; i < 4; i++) begin wdata[i] = dpat[i]; wstrb[i] = 8'hff; end
    do_write(Base + 32'h40, 8'd3, 3'd3, BInc, 5'h03, 3);
    n_checks++;
    if ({bresp, bid} !== {2'b00, 5'h03}) $display("FAIL incr_w_b: resp=%b id=%h required 00 03", bresp, bid);
    else n_pass++;
    do_read(Base + 32'h40, 8'd3, 3'd3, BInc, 5'h0a, -1);
    n_checks++;
    if (rlat !== 4) $display("FAIL incr_r_latency: got %0d required 4", rlat);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (rdata[i] !== dpat[i] || rresp[i] !== 2'b00 || rlast[i] !== (i == 3))
        $display("FAIL incr_r_beat%0d: data=%h resp=%b last=%b required %h 00 %b",
                 i, rdata[i], rresp[i], rlast[i], dpat[i], (i == 3));
      else n_pass++;
    end
    n_checks++;
    if ({rid, ar_busy_ok, b2b_ok, end_ok} !== {5'h0a, 3'b111})
      $display("FAIL incr_r_flow: id=%h ar_busy_ok=%b b2b=%b end=%b required 0a 1 1 1",
               rid, ar_busy_ok, b2b_ok, end_ok);
    else n_pass++;
  endtask

  task automatic test_wrap_write();
    for (int i = 0; i < 4; i++) begin wdata[i] = wpat[i]; wstrb[i] = 8'hff; end
    do_write(Base + 32'h18, 8'd3, 3'd3, BWrp, 5'h11, 3);
    n_checks++;
    if ({bresp, bid, wlat} !== {2'b00, 5'h11, 32'd2})
      $display("FAIL wrap_b: resp=%b id=%h latency=%0d required 00 11 2", bresp, bid, wlat);
    else n_pass++;
    do_read(Base, 8'd3, 3'd3, BInc, 5'h01, -1);
    n_checks++;
    if (rdata[0] !== wpat[1] || rdata[1] !== wpat[2] || rdata[2] !== wpat[3] || rdata[3] !== wpat[0])
      $display("FAIL wrap_readback: got %h %h %h %h required %h %h %h %h",
               rdata[0], rdata[1], rdata[2], rdata[3], wpat[1], wpat[2], wpat[3], wpat[0]);
    else n_pass++;
  endtask

  task automatic test_narrow_fixed();
    wdata[0] = 64'h1122_3344_5566_7788; wstrb[0] = 8'hff;
    do_write(Base + 32'h80, 8'd0, 3'd3, BInc, 5'h01, 0);
    for (int i = 0; i < 4; i++) begin
      wdata[i] = 64'hffff_ffff_ffff_ffa1 + 64'(i); wstrb[i] = 8'h01;
    end
    do_write(Base + 32'h80, 8'd3, 3'd0, BFix, 5'h02, 3);
    n_checks++;
    if (bresp !== 2'b00) $display("FAIL narrow_b: resp=%b required 00", bresp);
    else n_pass++;
    do_read(Base + 32'h80, 8'd0, 3'd3, BInc, 5'h02, -1);
    n_checks++;
    if (rdata[0] !== 64'h1122_3344_5566_77a4 || rlast[0] !== 1'b1)
      $display("FAIL narrow_readback: data=%h last=%b required 11223344556677a4 1", rdata[0], rlast[0]);
    else n_pass++;
  endtask

  task automatic test_errors();
    do_read(Base + 32'h800, 8'd2, 3'd3, BInc, 5'h15, -1);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (rdata[i] !== 64'd0 || rresp[i] !== 2'b11 || rlast[i] !== (i == 2))
        $display("FAIL decerr_r_beat%0d: data=%h resp=%b last=%b required 0 11 %b",
                 i, rdata[i], rresp[i], rlast[i], (i == 2));
      else n_pass++;
    end
    n_checks++;
    if (rid !== 5'h15) $display("FAIL decerr_r_id: got %h required 15", rid);
    else n_pass++;
    do_read(Base - 32'h8, 8'd0, 3'd3, BInc, 5'h00, -1);
    n_checks++;
    if (rdata[0] !== 64'd0 || rresp[0] !== 2'b11)
      $display("FAIL below_base: data=%h resp=%b required 0 11", rdata[0], rresp[0]);
    else n_pass++;
    do_read(Base, 8'd0, 3'd4, BInc, 5'h00, -1);
    n_checks++;
    if (rdata[0] !== 64'd0 || rresp[0] !== 2'b10)
      $display("FAIL bad_size: data=%h resp=%b required 0 10", rdata[0], rresp[0]);
    else n_pass++;
    wdata[0] = 64'hdead_beef_dead_beef; wstrb[0] = 8'hff;
    do_write(Base + 32'h800, 8'd0, 3'd3, BInc, 5'h04, 0);
    n_checks++;
    if ({bresp, bid} !== {2'b11, 5'h04}) $display("FAIL decerr_b: resp=%b id=%h required 11 04", bresp, bid);
    else n_pass++;
    do_read(Base, 8'd0, 3'd3, BInc, 5'h00, -1);
    n_checks++;
    if (rdata[0] !== wpat[1]) $display("FAIL decerr_no_write: word0=%h required %h", rdata[0], wpat[1]);
    else n_pass++;
    wdata[0] = 64'h1; wdata[1] = 64'h2; wstrb[0] = 8'hff; wstrb[1] = 8'hff;
    do_write(Base + 32'hc0, 8'd3, 3'd3, BInc, 5'h06, 1);
    n_checks++;
    if (bresp !== 2'b10) $display("FAIL early_last: resp=%b required 10", bresp);
    else n_pass++;
    do_write(Base + 32'hc0, 8'd0, 3'd3, BInc, 5'h07, 0);
    n_checks++;
    if ({bresp, bid} !== {2'b00, 5'h07}) $display("FAIL after_early_last: resp=%b id=%h required 00 07", bresp, bid);
    else n_pass++;
  endtask

  task automatic test_stall();
    do_read(Base + 32'h40, 8'd3, 3'd3, BInc, 5'h07, 1);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (rdata[i] !== dpat[i]) $display("FAIL stall_beat%0d: data=%h required %h", i, rdata[i], dpat[i]);
      else n_pass++;
    end
    n_checks++;
    if ({stall_ok, ar_busy_ok, end_ok} !== 3'b111)
      $display("FAIL stall_flow: stable=%b ar_busy_ok=%b end=%b required 111", stall_ok, ar_busy_ok, end_ok);
    else n_pass++;
  endtask

  task automatic test_reset_mid_burst();
    int t;
    ar_addr = Base; ar_len = 8'd7; ar_size = 3'd3; ar_burst = BInc; ar_id = 5'h09; ar_valid = 1'b1;
    r_ready = 1'b1;
    t = 0;
    @(negedge clock);
    while (!ar_ready && t < 50) begin @(negedge clock); t++; end
    @(posedge clock); #1 ar_valid = 1'b0;
    for (int b = 0; b < 3; b++) begin
      t = 0;
      @(negedge clock);
      while (!r_valid && t < 50) begin @(negedge clock); t++; end
      if (b < 2) begin @(posedge clock); #1; end
    end
    n_checks++;
    if (r_valid !== 1'b1) $display("FAIL midburst_beat2: r_valid=%b required 1", r_valid);
    else n_pass++;
    reset = 1'b0;
    #1;
    n_checks++;
    if ({r_valid, ar_ready, r_last} !== 3'b000 || r_data !== 64'd0)
      $display("FAIL async_reset: r_valid=%b ar_ready=%b r_last=%b r_data=%h required 0 0 0 0",
               r_valid, ar_ready, r_last, r_data);
    else n_pass++;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    n_checks++;
    if (ar_ready !== 1'b1) $display("FAIL post_reset_ready: ar_ready=%b required 1", ar_ready);
    else n_pass++;
    do_read(Base + 32'h40, 8'd3, 3'd3, BInc, 5'h0b, -1);
    n_checks++;
    if (rdata[0] !== dpat[0] || rdata[3] !== dpat[3] || rlast[3] !== 1'b1)
      $display("FAIL post_reset_data: beat0=%h beat3=%h last=%b required %h %h 1",
               rdata[0], rdata[3], rlast[3], dpat[0], dpat[3]);
    else n_pass++;
  endtask

  initial begin
    dpat = '{64'h0123_4567_89ab_cde0, 64'h0123_4567_89ab_cde1,
             64'h0123_4567_89ab_cde2, 64'h0123_4567_89ab_cde3};
    wpat = '{64'haaaa_0000_0000_0000, 64'haaaa_0000_0000_0001,
             64'haaaa_0000_0000_0002, 64'haaaa_0000_0000_0003};
    reset = 1'b0;
    aw_valid = 1'b0; aw_addr = '0; aw_len = '0; aw_size = '0; aw_burst = '0; aw_id = '0;
    w_valid = 1'b0; w_data = '0; w_strb = '0; w_last = 1'b0;
    b_ready = 1'b1;
    ar_valid = 1'b0; ar_addr = '0; ar_len = '0; ar_size = '0; ar_burst = '0; ar_id = '0;
    r_ready = 1'b1;
    test_reset();
    test_incr_read();
    test_wrap_write();
    test_narrow_fixed();
    test_errors();
    test_stall();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
